parking_occupancy_ctrl: RTL and testbench
=========================================

Name: parking_occupancy_ctrl

Overview:
- Multi-gate parking occupancy controller.
- Each gate has an outer sensor (a) and an inner sensor (b). Raw sensor inputs are synchronised and debounced per sensor.
- A per-gate direction FSM recognises complete entry or exit sequences and rejects aborted ones.
- All gate events are merged into one saturating occupancy counter with full/empty flags and sticky error flags. The block sits between the sensor pins and the display/barrier logic, replacing the fixed 3-bit single-gate counter chain.

Parameters:
- NUM_GATES, 2: number of gates (sensor pairs); must be 1..8.
- CAPACITY, 7: maximum occupancy; must be >= 1. Counter width CNT_W = $clog2(CAPACITY+1).
- DEB_CYCLES, 16: consecutive stable cycles required before a debounced sensor changes; must be >= 1.

Ports:
- clk  in  1  system clock; all state is clocked on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sens_a  in  NUM_GATES  raw outer sensor per gate, asynchronous, 1 = vehicle present.
- sens_b  in  NUM_GATES  raw inner sensor per gate, asynchronous, 1 = vehicle present.
- clear  in  1  synchronous clear: count and errors to 0, FSMs to IDLE.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- entry_pulse  out  NUM_GATES  one-cycle pulse per completed entry.
- exit_pulse  out  NUM_GATES  one-cycle pulse per completed exit.
- ovf_err  out  1  sticky; set when an entry was dropped at capacity.
- unf_err  out  1  sticky; set when an exit was dropped at zero.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - Sync flops, debounced values and debounce counters go to 0.
  - FSMs go to IDLE.
  - count = 0, entry_pulse = 0, exit_pulse = 0, ovf_err = 0, unf_err = 0.
  - Therefore empty = 1 and full = 0.
- Synchroniser: two-flop synchroniser per sensor bit.
- Debounce, per sensor:
  - A counter increments while the synced value differs from the clean value and resets to 0 when they are equal.
  - When the counter reaches DEB_CYCLES, clean takes the synced value and the counter resets.
  - Pin-to-clean latency = 2 + DEB_CYCLES cycles. Any pulse shorter than DEB_CYCLES cycles is filtered out.
- Direction FSM, per gate, on the clean pair {a,b}:
  - States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3.
  - IDLE: 10 -> EN1; 01 -> EX1; 11 -> stay IDLE (ambiguous start).
  - Entry path: EN1 --11--> EN2 --01--> EN3 --00--> IDLE, and the EN3 -> IDLE transition raises the entry event.
  - Exit path: EX1 --11--> EX2 --10--> EX3 --00--> IDLE, and the EX3 -> IDLE transition raises the exit event.
  - An unchanged pair keeps the current state.
  - A step back along the same path (for example EN2 seeing 10) returns to the previous state.
  - Any other pair, including 00 before the final step, -> IDLE with no event (abort).
- Event pulses:
  - entry_pulse[g] and exit_pulse[g] are registered.
  - Each is high for exactly one cycle: the cycle after the FSM leaves EN3 or EX3.
- Counter:
  - In the cycle that pulses are high: net = (number of entry_pulse bits set) - (number of exit_pulse bits set), computed signed at width CNT_W+4.
  - next = count + net.
  - If next > CAPACITY: count = CAPACITY and ovf_err is set.
  - If next < 0: count = 0 and unf_err is set.
  - Otherwise count = next.
  - The new count is visible one cycle after the pulse.
  - Simultaneous entries and exits on different gates are netted before saturation is applied.
- full and empty are combinational from count.
- clear:
  - Takes priority over events in the same cycle. Events in that cycle are discarded.
  - Does not affect synchronisers or debouncers.
- rst_n asserted mid-sequence aborts everything immediately. After release, a sensor already high produces a fresh debounced edge after 2 + DEB_CYCLES cycles.

Test Plan:
Bench parameters: NUM_GATES = 2, CAPACITY = 3, DEB_CYCLES = 4. Every sensor step is held for 10 cycles.
1. Reset: hold rst_n = 0 with all sensors 0 -> count = 0, empty = 1, full = 0, no pulses, ovf_err = unf_err = 0.
2. Entry on gate 0: drive {a,b} = 10, 11, 01, 00 -> exactly one entry_pulse[0] cycle; count = 1 the cycle after.
3. Abort and glitch on gate 1: drive 01, 11, 00 -> no pulse and count unchanged. Then a 3-cycle a glitch -> clean never changes.
4. Saturation: drive 3 entries, then a 4th entry -> count stays 3, full = 1, ovf_err = 1. Then pulse clear -> count = 0, ovf_err = 0.
5. Simultaneous events at count = 2: entry on gate 0 and exit on gate 1 completing in the same cycle -> both pulses high, count = 2.
   Then, from count = 2, two simultaneous entries -> count = 3 and ovf_err = 1.
6. Exit on gate 1 at count = 0 -> exit_pulse[1] high, count = 0, unf_err = 1.
   Then assert rst_n low asynchronously midway through an entry sequence (in EN2) -> all outputs 0 without waiting for a clock edge, and no pulse after release.

Source files
------------

// File: rtl/parking_occupancy_ctrl.sv
// Multi-gate parking occupancy controller.
// Each gate has an outer (a) and inner (b) sensor. Raw sensor pins are
// synchronised and debounced. A direction FSM per gate turns a clean
// a/b sequence into entry or exit events. All events are netted into one
// saturating occupancy counter with full/empty flags and sticky
// overflow/underflow error flags.
// There is no valid/ready handshake: sensors are level inputs and the
// entry/exit pulses are single-cycle strobes with no back-pressure.
module parking_occupancy_ctrl #(
  parameter int NUM_GATES  = 2,
  parameter int CAPACITY   = 7,
  parameter int DEB_CYCLES = 16,
  localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_GATES-1:0] sens_a,
  input  logic [NUM_GATES-1:0] sens_b,
  input  logic                 clear,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic [NUM_GATES-1:0] entry_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic                 ovf_err,
  output logic                 unf_err
);

  // Sensor vector: bits [NUM_GATES-1:0] are the a sensors, the upper half the b sensors.
  localparam int NS = 2 * NUM_GATES;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int NW = CNT_W + 4;
  localparam logic [DW-1:0]        DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic signed [NW-1:0] CAP_S    = NW'(CAPACITY);
  localparam logic [CNT_W-1:0]     CAP_C    = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EN1  = 3'd1,
    S_EN2  = 3'd2,
    S_EN3  = 3'd3,
    S_EX1  = 3'd4,
    S_EX2  = 3'd5,
    S_EX3  = 3'd6
  } gate_state_t;

  logic [NS-1:0]  raw;
  logic [NS-1:0]  sync1;
  logic [NS-1:0]  sync2;
  logic [NS-1:0]  clean;
  logic [DW-1:0]  deb_cnt [NS];
  logic [1:0]     pair [NUM_GATES];
  gate_state_t    gate_state [NUM_GATES];
  logic signed [NW-1:0] net;
  logic signed [NW-1:0] nxt;

  assign raw = {sens_b, sens_a};

  // Two-flop synchroniser, then a stability counter: clean follows sync2
  // only after sync2 has differed from it for DEB_CYCLES consecutive cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      clean <= '0;
      for (int i = 0; i < NS; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NS; i++) begin
        if (sync2[i] == clean[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          clean[i]   <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Gather the clean {a,b} pair for each gate.
  always_comb begin
    for (int g = 0; g < NUM_GATES; g++) pair[g] = {clean[g], clean[NUM_GATES + g]};
  end

  // Per-gate direction FSM with registered one-cycle entry/exit strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_GATES; g++) gate_state[g] <= S_IDLE;
      entry_pulse <= '0;
      exit_pulse  <= '0;
    end else if (clear) begin
      for (int g = 0; g < NUM_GATES; g++) gate_state[g] <= S_IDLE;
      entry_pulse <= '0;
      exit_pulse  <= '0;
    end else begin
      for (int g = 0; g < NUM_GATES; g++) begin
        entry_pulse[g] <= 1'b0;
        exit_pulse[g]  <= 1'b0;
        case (gate_state[g])
          S_IDLE: begin
            if (pair[g] == 2'b10)      gate_state[g] <= S_EN1;
            else if (pair[g] == 2'b01) gate_state[g] <= S_EX1;
          end
          S_EN1: begin
            if (pair[g] == 2'b11)      gate_state[g] <= S_EN2;
            else if (pair[g] != 2'b10) gate_state[g] <= S_IDLE;
          end
          S_EN2: begin
            if (pair[g] == 2'b01)      gate_state[g] <= S_EN3;
            else if (pair[g] == 2'b10) gate_state[g] <= S_EN1;
            else if (pair[g] != 2'b11) gate_state[g] <= S_IDLE;
          end
          S_EN3: begin
            if (pair[g] == 2'b00) begin
              gate_state[g]  <= S_IDLE;
              entry_pulse[g] <= 1'b1;
            end else if (pair[g] == 2'b11) begin
              gate_state[g] <= S_EN2;
            end else if (pair[g] != 2'b01) begin
              gate_state[g] <= S_IDLE;
            end
          end
          S_EX1: begin
            if (pair[g] == 2'b11)      gate_state[g] <= S_EX2;
            else if (pair[g] != 2'b01) gate_state[g] <= S_IDLE;
          end
          S_EX2: begin
            if (pair[g] == 2'b10)      gate_state[g] <= S_EX3;
            else if (pair[g] == 2'b01) gate_state[g] <= S_EX1;
            else if (pair[g] != 2'b11) gate_state[g] <= S_IDLE;
          end
          S_EX3: begin
            if (pair[g] == 2'b00) begin
              gate_state[g] <= S_IDLE;
              exit_pulse[g] <= 1'b1;
            end else if (pair[g] == 2'b11) begin
              gate_state[g] <= S_EX2;
            end else if (pair[g] != 2'b10) begin
              gate_state[g] <= S_IDLE;
            end
          end
          default: gate_state[g] <= S_IDLE;
        endcase
      end
    end
  end

  // Net all strobes of this cycle before saturation so simultaneous
  // entries and exits on different gates cancel out first.
  always_comb begin
    net = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      net = net + NW'(entry_pulse[g]);
      net = net - NW'(exit_pulse[g]);
    end
    nxt = NW'(count) + net;
  end

  // Saturating occupancy counter with sticky error flags; clear wins over events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else if (nxt[NW-1]) begin
      count   <= '0;
      unf_err <= 1'b1;
    end else if (nxt > CAP_S) begin
      count   <= CAP_C;
      ovf_err <= 1'b1;
    end else begin
      count <= nxt[CNT_W-1:0];
    end
  end

  assign full  = (count == CAP_C);
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl with NUM_GATES=2, CAPACITY=3,
// DEB_CYCLES=4. Every sensor step is held for 10 cycles, which covers the
// 6-cycle pin-to-clean latency plus FSM, strobe and count registers.
module tb_parking_occupancy_ctrl;

  localparam int NG   = 2;
  localparam int CAP  = 3;
  localparam int DEB  = 4;
  localparam int CW   = 2;
  localparam int HOLD = 10;

  // Clock and reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NG-1:0] sens_a;
  logic [NG-1:0] sens_b;
  logic          clear;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [NG-1:0] entry_pulse;
  logic [NG-1:0] exit_pulse;
  logic          ovf_err;
  logic          unf_err;

  parking_occupancy_ctrl #(
    .NUM_GATES (NG),
    .CAPACITY  (CAP),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sens_a     (sens_a),
    .sens_b     (sens_b),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .entry_pulse(entry_pulse),
    .exit_pulse (exit_pulse),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  int checks = 0;
  int errors = 0;

  // Strobe monitor: cumulative number of cycles each strobe was seen high.
  int ent_hi [NG] = '{0, 0};
  int ext_hi [NG] = '{0, 0};
  int mixed_hi    = 0;
  int dual_ent_hi = 0;
  bit glitch_win  = 1'b0;
  bit glitch_seen = 1'b0;

  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      if (entry_pulse[g] === 1'b1) ent_hi[g] = ent_hi[g] + 1;
      if (exit_pulse[g] === 1'b1)  ext_hi[g] = ext_hi[g] + 1;
    end
    if (entry_pulse[0] === 1'b1 && exit_pulse[1] === 1'b1) mixed_hi = mixed_hi + 1;
    if (entry_pulse === 2'b11) dual_ent_hi = dual_ent_hi + 1;
    if (glitch_win && dut.clean[1] !== 1'b0) glitch_seen = 1'b1;
  end

  logic [1:0] ent_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ext_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive {a,b} of gate 0 and gate 1, then hold.
  task automatic drive(input logic [1:0] p0, input logic [1:0] p1);
    sens_a = {p1[1], p0[1]};
    sens_b = {p1[0], p0[0]};
    cycles(HOLD);
  endtask

  // Full sequence; each gate may do an entry, an exit, or stay idle.
  task automatic seq(input bit g0_ent, input bit g0_ext, input bit g1_ent, input bit g1_ext);
    logic [1:0] p0;
    logic [1:0] p1;
    for (int i = 0; i < 4; i++) begin
      p0 = g0_ent ? ent_seq[i] : (g0_ext ? ext_seq[i] : 2'b00);
      p1 = g1_ent ? ent_seq[i] : (g1_ext ? ext_seq[i] : 2'b00);
      drive(p0, p1);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cycles(1);
    clear = 1'b0;
    cycles(1);
  endtask

  initial begin
    sens_a = '0;
    sens_b = '0;
    clear  = 1'b0;
    rst_n  = 1'b0;
    cycles(3);

    // 1. Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_entry", 32'(entry_pulse), 0);
    chk("rst_exit", 32'(exit_pulse), 0);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_unf", 32'(unf_err), 0);
    rst_n = 1'b1;
    cycles(2);

    // 2. Entry on gate 0
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    chk("entry0_count", 32'(count), 1);
    chk("entry0_pulse_cycles", 32'(ent_hi[0]), 1);
    chk("entry0_no_exit", 32'(ext_hi[0] + ext_hi[1]), 0);
    chk("entry0_empty", 32'(empty), 0);

    // 3. Aborted exit on gate 1, then a short glitch on its a sensor
    drive(2'b00, 2'b01);
    drive(2'b00, 2'b11);
    drive(2'b00, 2'b00);
    chk("abort_count", 32'(count), 1);
    chk("abort_exit1", 32'(ext_hi[1]), 0);
    chk("abort_entry1", 32'(ent_hi[1]), 0);
    glitch_win = 1'b1;
    sens_a[1]  = 1'b1;
    cycles(3);
    sens_a[1]  = 1'b0;
    cycles(HOLD);
    glitch_win = 1'b0;
    chk("glitch_filtered", 32'(glitch_seen), 0);
    chk("glitch_count", 32'(count), 1);

    // 4. Saturation at capacity
    pulse_clear();
    chk("clear_count", 32'(count), 0);
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    chk("cap_count", 32'(count), 3);
    chk("cap_full", 32'(full), 1);
    chk("cap_ovf_clear", 32'(ovf_err), 0);
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovf_count", 32'(count), 3);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_err", 32'(ovf_err), 1);
    chk("ovf_pulses", 32'(ent_hi[0]), 5);
    pulse_clear();
    chk("clr_count", 32'(count), 0);
    chk("clr_ovf", 32'(ovf_err), 0);
    chk("clr_empty", 32'(empty), 1);

    // 5. Simultaneous events
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    seq(1'b1, 1'b0, 1'b0, 1'b0);
    chk("two_count", 32'(count), 2);
    seq(1'b1, 1'b0, 1'b0, 1'b1);
    chk("mixed_same_cycle", 32'(mixed_hi), 1);
    chk("mixed_exit1", 32'(ext_hi[1]), 1);
    chk("mixed_count", 32'(count), 2);
    chk("mixed_ovf", 32'(ovf_err), 0);
    seq(1'b1, 1'b0, 1'b1, 1'b0);
    chk("dual_same_cycle", 32'(dual_ent_hi), 1);
    chk("dual_entry1", 32'(ent_hi[1]), 1);
    chk("dual_count", 32'(count), 3);
    chk("dual_ovf", 32'(ovf_err), 1);

    // 6. Exit at zero, then asynchronous reset mid-entry
    pulse_clear();
    chk("clr2_count", 32'(count), 0);
    seq(1'b0, 1'b0, 1'b0, 1'b1);
    chk("unf_pulses", 32'(ext_hi[1]), 2);
    chk("unf_count", 32'(count), 0);
    chk("unf_err", 32'(unf_err), 1);
    chk("unf_empty", 32'(empty), 1);

    drive(2'b10, 2'b00);
    drive(2'b11, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_unf", 32'(unf_err), 0);
    chk("async_count", 32'(count), 0);
    chk("async_empty", 32'(empty), 1);
    chk("async_entry", 32'(entry_pulse), 0);
    chk("async_exit", 32'(exit_pulse), 0);
    cycles(3);
    rst_n = 1'b1;
    drive(2'b11, 2'b00);
    drive(2'b01, 2'b00);
    drive(2'b00, 2'b00);
    cycles(HOLD);
    chk("post_rst_entry0", 32'(ent_hi[0]), 9);
    chk("post_rst_exit0", 32'(ext_hi[0]), 0);
    chk("post_rst_count", 32'(count), 0);
    chk("post_rst_unf", 32'(unf_err), 0);
    chk("post_rst_ovf", 32'(ovf_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
